// File: rtl/seq_csa_multiplier.sv
// seq_csa_multiplier: sequential carry-save multiplier, R partial-product rows folded per cycle.
// Ports:
//   clk       - clock; all state changes on its rising edge
//   rst_n     - asynchronous active-low reset
//   start     - begin a multiply; only looked at while busy=0
//   is_signed - 1 = two's-complement operands, 0 = unsigned (sampled with start)
//   x, y      - W-bit multiplicand / multiplier (sampled with start)
//   busy      - high while an operation is in ACCUM or RESOLVE
//   done      - one-cycle pulse when p holds a new product
//   p         - registered 2W-bit product
module seq_csa_multiplier #(
    parameter int W = 8,
    parameter int R = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           is_signed,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);
    localparam int CW = $clog2(W + 1);
    generate
        if (W < 2 || W > 32 || R < 1 || (W % R) != 0) begin : g_bad_params
            $error("seq_csa_multiplier: W must be 2..32 and a multiple of R");
        end
    endgenerate
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE} state_t;
    state_t         state_q, state_d;
    logic [W-1:0]   x_q, x_d, y_q, y_d;
    logic           sgn_q, sgn_d, done_q, done_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] s_q, s_d, c_q, c_d, p_q, p_d;
    logic [2*W-1:0] ye, ny, s_acc, c_acc;
    // Rows are sign-extended to the full 2W width so all arithmetic is modulo 2^(2W);
    // in signed mode the top row carries negative weight and adds -y instead of y.
    assign ye = {{W{sgn_q & y_q[W-1]}}, y_q};
    assign ny = -ye;
    // Rows are added at their final bit position, so after row k the carry vector is zero
    // at bits 0..k and the sum bits below k are finished product bits.
    always_comb begin
        logic [2*W-1:0] pp, t;
        logic [W-1:0]   xs;
        pp = '0;
        t = '0;
        xs = '0;
        s_acc = s_q;
        c_acc = c_q;
        for (int r = 0; r < R; r++) begin
            xs = x_q >> (int'(cnt_q) + r);
            pp = xs[0] ? (((sgn_q && (int'(cnt_q) + r == W - 1)) ? ny : ye) << (int'(cnt_q) + r)) : '0;
            t = s_acc ^ c_acc ^ pp;
            c_acc = ((s_acc & c_acc) | (s_acc & pp) | (c_acc & pp)) << 1;
            s_acc = t;
        end
    end
    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        sgn_d = sgn_q;
        s_d = s_q;
        c_d = c_q;
        cnt_d = cnt_q;
        p_d = p_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d = x;
                    y_d = y;
                    sgn_d = is_signed;
                    s_d = '0;
                    c_d = '0;
                    cnt_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                s_d = s_acc;
                c_d = c_acc;
                cnt_d = cnt_q + CW'(R);
                state_d = (cnt_q + CW'(R) == CW'(W)) ? RESOLVE : ACCUM;
            end
            RESOLVE: begin
                // Low W carry bits are zero here, so only the upper half needs a real add.
                p_d = {s_q[2*W-1:W] + c_q[2*W-1:W], s_q[W-1:0]};
                done_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            sgn_q <= 1'b0;
            s_q <= '0;
            c_q <= '0;
            cnt_q <= '0;
            p_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            sgn_q <= sgn_d;
            s_q <= s_d;
            c_q <= c_d;
            cnt_q <= cnt_d;
            p_q <= p_d;
            done_q <= done_d;
        end
    end
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign p = p_q;
endmodule

// File: tb/tb_seq_csa_multiplier.sv
// tb_seq_csa_multiplier: checks seq_csa_multiplier (W=8,R=2 and W=16,R=4) against a cycle-level reference.
// Ports: none (top-level bench).
module tb_seq_csa_multiplier;
    localparam int W = 8;
    localparam int R = 2;
    localparam int LAT = W / R + 1;
    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic           is_signed = 1'b0;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   y = '0;
    logic           busy, done;
    logic [2*W-1:0] p;
    logic           rst2_n = 1'b0;
    logic           st2 = 1'b0;
    logic           sg2 = 1'b0;
    logic [15:0]    x2 = '0;
    logic [15:0]    y2 = '0;
    logic           busy2, done2;
    logic [31:0]    p2;
    bit             sweep_done = 1'b0;
    int             total = 0;
    int             bad = 0;
    always #5 clk = ~clk;
    seq_csa_multiplier #(.W(W), .R(R)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .x(x), .y(y), .busy(busy), .done(done), .p(p)
    );
    seq_csa_multiplier #(.W(16), .R(4)) dut16 (
        .clk(clk), .rst_n(rst2_n), .start(st2), .is_signed(sg2),
        .x(x2), .y(y2), .busy(busy2), .done(done2), .p(p2)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [2*W-1:0] ref8(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb;
        ea = {{W{s & a[W-1]}}, a};
        eb = {{W{s & b[W-1]}}, b};
        return ea * eb;
    endfunction
    // Reference: an accepted start yields the product LAT edges later; busy while pending.
    int             rem = 0;
    logic [2*W-1:0] pend = '0;
    logic [2*W-1:0] m_p = '0;
    logic           m_done = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem = 0;
            m_p = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_p = pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                pend = ref8(is_signed, x, y);
                rem = LAT;
            end
        end
    end
    always @(negedge clk) begin
        chk("cyc_busy", busy, rem != 0);
        chk("cyc_done", done, m_done);
        chk("cyc_p", p, m_p);
    end
    task automatic op(input string nm, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] e, input bit glitch, input bit now);
        int n, bc;
        if (!now) @(negedge clk);
        start = 1'b1;
        is_signed = s;
        x = a;
        y = b;
        @(negedge clk);
        start = 1'b0;
        is_signed = ~s;
        x = ~a;
        y = b ^ 8'h5A;
        n = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 20) begin
            if (glitch) begin
                start = (n == 1);
                x = 8'h03;
                y = 8'h03;
            end
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        start = 1'b0;
        chk({nm, "_p"}, p, e);
        chk({nm, "_lat"}, n, LAT);
        chk({nm, "_busy"}, bc, LAT);
        @(negedge clk);
        chk({nm, "_pulse"}, done, 1'b0);
    endtask
    initial begin
        logic [W-1:0]   ba [4] = '{8'h12, 8'hFE, 8'hAA, 8'h7F};
        logic [W-1:0]   bb [4] = '{8'h34, 8'h03, 8'h55, 8'h81};
        logic           bs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2*W-1:0] be [4] = '{16'h03A8, 16'hFFFA, 16'h3872, 16'hC0FF};
        int n;
        #2 rst_n = 1'b0;
        #1;
        chk("rst0_busy", busy, 1'b0);
        chk("rst0_done", done, 1'b0);
        chk("rst0_p", p, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op("u_ffff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0);
        op("s_8080", 1'b1, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0);
        op("s_ff01", 1'b1, 8'hFF, 8'h01, 16'hFFFF, 1'b0, 1'b0);
        op("s_807f", 1'b1, 8'h80, 8'h7F, 16'hC080, 1'b0, 1'b0);
        op("u_807f", 1'b0, 8'h80, 8'h7F, 16'h3F80, 1'b0, 1'b0);
        op("s_ffff", 1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0, 1'b0);
        op("s_7f7f", 1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b0, 1'b0);
        op("u_zero", 1'b0, 8'h00, 8'hC3, 16'h0000, 1'b0, 1'b0);
        op("ignore", 1'b0, 8'h0B, 8'h0D, 16'h008F, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b1;
        is_signed = bs[0];
        x = ba[0];
        y = bb[0];
        @(negedge clk);
        is_signed = bs[1];
        x = ba[1];
        y = bb[1];
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!done && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_p", p, be[i]);
            chk("b2b_gap", n, LAT);
            @(negedge clk);
            start = (i + 2 < 4);
            if (i + 2 < 4) begin
                is_signed = bs[i+2];
                x = ba[i+2];
                y = bb[i+2];
            end
        end
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        is_signed = 1'b0;
        x = 8'h21;
        y = 8'h13;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_p", p, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op("after_rst", 1'b0, 8'h03, 8'h05, 16'h000F, 1'b0, 1'b1);
        n = 0;
        while (!sweep_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_finished", sweep_done, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        logic [15:0] a, b;
        logic [31:0] e, ea, eb;
        logic        s;
        int          n;
        repeat (3) @(negedge clk);
        rst2_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = (i < 2) ? 16'h8000 : 16'($urandom);
            b = (i < 2) ? 16'h8000 : 16'($urandom);
            s = (i < 2) ? i[0] : 1'($urandom_range(0, 1));
            ea = {{16{s & a[15]}}, a};
            eb = {{16{s & b[15]}}, b};
            e = ea * eb;
            @(negedge clk);
            st2 = 1'b1;
            sg2 = s;
            x2 = a;
            y2 = b;
            @(negedge clk);
            st2 = 1'b0;
            x2 = 16'($urandom);
            y2 = 16'($urandom);
            sg2 = ~s;
            n = 0;
            while (!done2 && n < 30) begin
                @(negedge clk);
                n++;
            end
            chk("w16_p", p2, e);
            chk("w16_lat", n, 5);
        end
        sweep_done = 1'b1;
    end
endmodule
